// File: rtl/reg_file_wb_pkg.sv
// Shared definitions for the write-back register file: default geometry,
// special register values and the write-back select code.
package reg_file_wb_pkg;

    localparam int DATA_W_DEF   = 17;
    localparam int ADDR_W_DEF   = 4;
    localparam int SP_INDEX_DEF = 15;
    localparam int SP_RESET_DEF = 200;

    // Constants the write-back mux can select directly
    localparam logic [DATA_W_DEF-1:0] WB_CONST_95   = 17'd95;
    localparam logic [DATA_W_DEF-1:0] WB_CONST_200  = 17'd200;
    localparam logic [DATA_W_DEF-1:0] WB_CONST_NEG1 = 17'h1FFFF;

    typedef enum logic [3:0] {
        WB_SEL_ALU        = 4'd0,
        WB_SEL_MEM        = 4'd1,
        WB_SEL_PC_INC     = 4'd2,
        WB_SEL_IMM        = 4'd3,
        WB_SEL_CONST_95   = 4'd4,
        WB_SEL_CONST_200  = 4'd5,
        WB_SEL_CONST_NEG1 = 4'd6,
        WB_SEL_ZERO       = 4'd7
    } wb_sel_e;

    function automatic logic [DATA_W_DEF-1:0] wb_const_value(input wb_sel_e sel);
        case (sel)
            WB_SEL_CONST_95:   wb_const_value = WB_CONST_95;
            WB_SEL_CONST_200:  wb_const_value = WB_CONST_200;
            WB_SEL_CONST_NEG1: wb_const_value = WB_CONST_NEG1;
            default:           wb_const_value = '0;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Write/read bus of the register file: the write-back stage and operand
// stage side (master) against the register file (slave).
interface reg_file_wb_if #(
    parameter int DATA_W = 17,
    parameter int ADDR_W = 4
);
    logic              WriteEnable;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadAddrA;
    logic [ADDR_W-1:0] ReadAddrB;
    logic [DATA_W-1:0] ReadDataA;
    logic [DATA_W-1:0] ReadDataB;
    logic [15:0]       WriteCount;

    modport master (
        output WriteEnable, WriteAddr, WriteData, ReadAddrA, ReadAddrB,
        input  ReadDataA, ReadDataB, WriteCount
    );

    modport slave (
        input  WriteEnable, WriteAddr, WriteData, ReadAddrA, ReadAddrB,
        output ReadDataA, ReadDataB, WriteCount
    );
endinterface

// File: rtl/reg_file_wb_read_port.sv
// One combinational read port: index decode, zero-register gating and,
// when REGFILE_BYPASS_EN is defined, same-cycle write-through forwarding.
module reg_file_read_port #(
    parameter int DATA_W   = 17,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_fwd_valid,
    input  logic [ADDR_W-1:0] i_fwd_addr,
    input  logic [DATA_W-1:0] i_fwd_data,
    output logic [DATA_W-1:0] o_data
);
    logic w_is_zero;
    assign w_is_zero = (ZERO_REG != 0) && (i_addr == '0);

`ifdef REGFILE_BYPASS_EN
    logic w_fwd_hit;
    assign w_fwd_hit = i_fwd_valid && (i_fwd_addr == i_addr);

    always_comb begin
        o_data = i_regs[i_addr];
        if (w_is_zero)
            o_data = '0;
        else if (w_fwd_hit)
            o_data = i_fwd_data;
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{i_fwd_valid, i_fwd_addr, i_fwd_data};

    always_comb begin
        o_data = i_regs[i_addr];
        if (w_is_zero)
            o_data = '0;
    end
`endif

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file fed by the write-back mux, two read ports.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int SP_INDEX = SP_INDEX_DEF,
    parameter int SP_RESET = SP_RESET_DEF
) (
    input logic          i_Clock,
    input logic          i_Reset_n,
    reg_file_wb_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [15:0]       r_write_count;

    logic w_wr_suppress;
    logic w_wr_commit;
    logic w_fwd_valid;

    // WriteEnable is evaluated first so X on address/data while idle stays harmless
    assign w_wr_suppress = (ZERO_REG != 0) && (bus.WriteAddr == '0);
    assign w_wr_commit   = bus.WriteEnable && !w_wr_suppress;
    assign w_fwd_valid   = w_wr_commit && i_Reset_n;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
            r_write_count <= '0;
        end else if (w_wr_commit) begin
            r_regs[bus.WriteAddr] <= bus.WriteData;
            if (r_write_count != 16'hFFFF)
                r_write_count <= r_write_count + 16'd1;
        end
    end

    assign bus.WriteCount = r_write_count;

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_read_a (
        .i_regs      (r_regs),
        .i_addr      (bus.ReadAddrA),
        .i_fwd_valid (w_fwd_valid),
        .i_fwd_addr  (bus.WriteAddr),
        .i_fwd_data  (bus.WriteData),
        .o_data      (bus.ReadDataA)
    );

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_read_b (
        .i_regs      (r_regs),
        .i_addr      (bus.ReadAddrB),
        .i_fwd_valid (w_fwd_valid),
        .i_fwd_addr  (bus.WriteAddr),
        .i_fwd_data  (bus.WriteData),
        .o_data      (bus.ReadDataB)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb; two instances cover ZERO_REG=1 and ZERO_REG=0.
module tb_reg_file_wb;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_file_wb_if #(.DATA_W(17), .ADDR_W(4)) bus ();
    reg_file_wb_if #(.DATA_W(17), .ADDR_W(4)) bus_nz ();

    reg_file_wb #(.ZERO_REG(1)) u_dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus.slave)
    );

    reg_file_wb #(.ZERO_REG(0)) u_dut_nz (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus_nz.slave)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    string       tag_q [$];
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic check_v(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic idle_both();
        bus.WriteEnable    = 1'b0;
        bus_nz.WriteEnable = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.WriteEnable    = 1'b0;
        bus.WriteAddr      = '0;
        bus.WriteData      = '0;
        bus.ReadAddrA      = '0;
        bus.ReadAddrB      = '0;
        bus_nz.WriteEnable = 1'b0;
        bus_nz.WriteAddr   = '0;
        bus_nz.WriteData   = '0;
        bus_nz.ReadAddrA   = '0;
        bus_nz.ReadAddrB   = '0;

        // Reset held for two edges, then sweep all indices on both ports
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.ReadAddrA = 4'(i);
            bus.ReadAddrB = 4'(15 - i);
            expect_v($sformatf("reset_a_r%0d", i), (i == 15) ? 32'd200 : 32'd0);
            expect_v($sformatf("reset_b_r%0d", 15 - i), (i == 0) ? 32'd200 : 32'd0);
            #1;
            check_v(32'(bus.ReadDataA));
            check_v(32'(bus.ReadDataB));
        end
        expect_v("reset_count", 32'd0);
        check_v(32'(bus.WriteCount));

        // Basic write to r3; same-cycle read shows old value unless forwarding
        bus.WriteEnable = 1'b1;
        bus.WriteAddr   = 4'd3;
        bus.WriteData   = 17'h0ABCD;
        bus.ReadAddrA   = 4'd3;
        bus.ReadAddrB   = 4'd3;
        expect_v("wr_r3_same_cycle", BYPASS ? 32'h0ABCD : 32'd0);
        #1;
        check_v(32'(bus.ReadDataA));
        tick();
        bus.WriteEnable = 1'b0;
        expect_v("wr_r3_next_a", 32'h0ABCD);
        expect_v("wr_r3_next_b", 32'h0ABCD);
        expect_v("wr_r3_count", 32'd1);
        #1;
        check_v(32'(bus.ReadDataA));
        check_v(32'(bus.ReadDataB));
        check_v(32'(bus.WriteCount));

        // Overwrite r3 with -1: old value same cycle, full 17 bits next cycle
        bus.WriteEnable = 1'b1;
        bus.WriteData   = 17'h1FFFF;
        expect_v("raw_r3_same_a", BYPASS ? 32'h1FFFF : 32'h0ABCD);
        expect_v("raw_r3_same_b", BYPASS ? 32'h1FFFF : 32'h0ABCD);
        #1;
        check_v(32'(bus.ReadDataA));
        check_v(32'(bus.ReadDataB));
        tick();
        bus.WriteEnable = 1'b0;
        expect_v("raw_r3_next", 32'h1FFFF);
        expect_v("raw_r3_count", 32'd2);
        #1;
        check_v(32'(bus.ReadDataA));
        check_v(32'(bus.WriteCount));

        // Zero register on both builds
        bus.WriteEnable    = 1'b1;
        bus.WriteAddr      = 4'd0;
        bus.WriteData      = 17'h1FFFF;
        bus.ReadAddrA      = 4'd0;
        bus_nz.WriteEnable = 1'b1;
        bus_nz.WriteAddr   = 4'd0;
        bus_nz.WriteData   = 17'h1FFFF;
        bus_nz.ReadAddrA   = 4'd0;
        expect_v("zero_r0_same", 32'd0);
        expect_v("nz_r0_same", BYPASS ? 32'h1FFFF : 32'd0);
        #1;
        check_v(32'(bus.ReadDataA));
        check_v(32'(bus_nz.ReadDataA));
        tick();
        idle_both();
        expect_v("zero_r0_next", 32'd0);
        expect_v("zero_count", 32'd2);
        expect_v("nz_r0_next", 32'h1FFFF);
        expect_v("nz_count", 32'd1);
        #1;
        check_v(32'(bus.ReadDataA));
        check_v(32'(bus.WriteCount));
        check_v(32'(bus_nz.ReadDataA));
        check_v(32'(bus_nz.WriteCount));

        // Idle cycles with X on address/data must leave state untouched
        bus.WriteAddr = 'x;
        bus.WriteData = 'x;
        bus.ReadAddrA = 4'd3;
        tick();
        tick();
        expect_v("idle_x_r3", 32'h1FFFF);
        expect_v("idle_x_count", 32'd2);
        #1;
        check_v(32'(bus.ReadDataA));
        check_v(32'(bus.WriteCount));

        // Write r5, then reset coinciding with a write of 95 to r5
        bus.WriteEnable = 1'b1;
        bus.WriteAddr   = 4'd5;
        bus.WriteData   = 17'd200;
        tick();
        bus.ReadAddrA = 4'd5;
        expect_v("pre_rst_r5", 32'd200);
        #1;
        check_v(32'(bus.ReadDataA));
        bus.WriteData = 17'd95;
        rst_n         = 1'b0;
        tick();
        rst_n           = 1'b1;
        bus.WriteEnable = 1'b0;
        bus.ReadAddrB   = 4'd3;
        expect_v("rst_prio_r5", 32'd0);
        expect_v("rst_prio_r3", 32'd0);
        expect_v("rst_prio_count", 32'd0);
        expect_v("rst_prio_nz_r0", 32'd0);
        #1;
        check_v(32'(bus.ReadDataA));
        check_v(32'(bus.ReadDataB));
        check_v(32'(bus.WriteCount));
        check_v(32'(bus_nz.ReadDataA));
        bus.ReadAddrA = 4'd15;
        expect_v("rst_prio_sp", 32'd200);
        #1;
        check_v(32'(bus.ReadDataA));

        // Saturation: 65534 writes, then step across the 16'hFFFF ceiling
        bus.WriteEnable = 1'b1;
        bus.WriteAddr   = 4'd1;
        bus.ReadAddrA   = 4'd1;
        for (int i = 0; i < 65534; i++) begin
            bus.WriteData = 17'(i);
            tick();
        end
        expect_v("sat_count_fffe", 32'h0000FFFE);
        expect_v("sat_r1_last", 32'(17'(65533)));
        #1;
        check_v(32'(bus.WriteCount));
        check_v(32'(bus.ReadDataA));
        bus.WriteData = 17'h15555;
        tick();
        expect_v("sat_count_ffff", 32'h0000FFFF);
        #1;
        check_v(32'(bus.WriteCount));
        bus.WriteData = 17'h0AAAA;
        tick();
        expect_v("sat_count_hold", 32'h0000FFFF);
        expect_v("sat_r1_still_written", 32'h0AAAA);
        #1;
        check_v(32'(bus.WriteCount));
        check_v(32'(bus.ReadDataA));
        tick();
        bus.WriteEnable = 1'b0;
        expect_v("sat_count_hold2", 32'h0000FFFF);
        #1;
        check_v(32'(bus.WriteCount));

        if (exp_q.size() != 0) begin
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
